// File: rtl/mipsu_pkg.sv
// Shared encodings for the MEM/WB slice: load types and writeback FSM states.
// Optional LWL/LWR support in this slice is enabled with MIPSU_LWLR_EN.
package mipsu_pkg;

    typedef enum logic [2:0] {
        LD_NONE = 3'd0,
        LD_LB   = 3'd1,
        LD_LBU  = 3'd2,
        LD_LH   = 3'd3,
        LD_LHU  = 3'd4,
        LD_LW   = 3'd5,
        LD_LWL  = 3'd6,
        LD_LWR  = 3'd7
    } load_type_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_WB   = 2'd2
    } wb_state_e;

endpackage

// File: rtl/load_align.sv
// Combinational load data alignment/extension and misalignment detection.
// With MIPSU_LWLR_EN defined, LWL/LWR merge memory bytes into old_rt; otherwise they flag misalign.
module load_align
    import mipsu_pkg::*;
#(
    parameter int unsigned BIG_ENDIAN = 1
) (
    input  logic [31:0] mem_word,
    input  logic [1:0]  offset,
    input  load_type_e  load_type,
    input  logic [31:0] old_rt,
    output logic [31:0] data,
    output logic        misalign
);

    logic [1:0]  byte_idx;
    logic [7:0]  sel_byte;
    logic        half_hi;
    logic [15:0] sel_half;
    logic [4:0]  lwl_sh;
    logic [4:0]  lwr_sh;
    logic [31:0] lwl_data;
    logic [31:0] lwr_data;

    always_comb begin
        // Byte offset 0 is the most significant byte in big-endian mode.
        byte_idx = (BIG_ENDIAN != 0) ? ~offset : offset;
        sel_byte = mem_word[{byte_idx, 3'b000} +: 8];
        half_hi  = (BIG_ENDIAN != 0) ? ~offset[1] : offset[1];
        sel_half = half_hi ? mem_word[31:16] : mem_word[15:0];

        // Partial-word merges: shift memory into place, keep the uncovered rt bytes.
        lwl_sh   = {((BIG_ENDIAN != 0) ? offset : ~offset), 3'b000};
        lwr_sh   = {((BIG_ENDIAN != 0) ? ~offset : offset), 3'b000};
        lwl_data = (mem_word << lwl_sh) | (old_rt & ~({32{1'b1}} << lwl_sh));
        lwr_data = (mem_word >> lwr_sh) | (old_rt & ~({32{1'b1}} >> lwr_sh));

        data     = '0;
        misalign = 1'b0;
        case (load_type)
            LD_LB:  data = {{24{sel_byte[7]}}, sel_byte};
            LD_LBU: data = {24'b0, sel_byte};
            LD_LH: begin
                data     = {{16{sel_half[15]}}, sel_half};
                misalign = offset[0];
            end
            LD_LHU: begin
                data     = {16'b0, sel_half};
                misalign = offset[0];
            end
            LD_LW: begin
                data     = mem_word;
                misalign = (offset != 2'd0);
            end
            LD_LWL: begin
                data = lwl_data;
`ifdef MIPSU_LWLR_EN
                misalign = 1'b0;
`else
                misalign = 1'b1;
`endif
            end
            LD_LWR: begin
                data = lwr_data;
`ifdef MIPSU_LWLR_EN
                misalign = 1'b0;
`else
                misalign = 1'b1;
`endif
            end
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB stage: waits for load data, aligns it and drives the regfile write port and LL strobe.
// LWL/LWR are legal only when built with MIPSU_LWLR_EN (handled in load_align).
module mem_wb_stage
    import mipsu_pkg::*;
#(
    parameter int unsigned BIG_ENDIAN     = 1,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        InValid,
    output logic        InReady,
    input  logic        InRegWrite,
    input  logic [4:0]  InWriteReg,
    input  logic [31:0] InAluResult,
    input  logic [2:0]  InLoadType,
    input  logic        InIsLL,
    input  logic        InIsSC,
    input  logic [31:0] InOldRt,
    input  logic [31:0] MemRdData,
    input  logic        MemAck,
    input  logic        LLbitout,
    output logic        RegWrite,
    output logic [4:0]  WriteReg,
    output logic [31:0] WriteData,
    output logic        LLbitin,
    output logic        AddrErr,
    output logic        BusErr
);

    localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    wb_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic        regwrite_q, regwrite_d;
    logic [4:0]  wreg_q, wreg_d;
    logic [31:0] alu_q, alu_d;
    load_type_e  ltype_q, ltype_d;
    logic        ll_q, ll_d;
    logic [31:0] oldrt_q, oldrt_d;
    logic        reg_write_q, reg_write_d;
    logic [31:0] write_data_q, write_data_d;
    logic        llbit_set_q, llbit_set_d;
    logic        addr_err_q, addr_err_d;
    logic        bus_err_q, bus_err_d;
    logic        sc_wb_q, sc_wb_d;

    logic        in_ready;
    logic        accept;
    logic        in_wait;
    logic [1:0]  al_offset;
    load_type_e  al_type;
    logic [31:0] al_rt;
    logic [31:0] al_data;
    logic        al_misalign;

    assign in_wait  = (state_q == ST_WAIT);
    assign in_ready = (state_q == ST_IDLE) || (state_q == ST_WB);
    assign accept   = InValid && in_ready;

    // One aligner serves both uses: misalign check on the incoming op, data merge while waiting.
    assign al_offset = in_wait ? alu_q[1:0] : InAluResult[1:0];
    assign al_type   = in_wait ? ltype_q : load_type_e'(InLoadType);
    assign al_rt     = in_wait ? oldrt_q : InOldRt;

    load_align #(
        .BIG_ENDIAN(BIG_ENDIAN)
    ) u_align (
        .mem_word (MemRdData),
        .offset   (al_offset),
        .load_type(al_type),
        .old_rt   (al_rt),
        .data     (al_data),
        .misalign (al_misalign)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        regwrite_d   = regwrite_q;
        wreg_d       = wreg_q;
        alu_d        = alu_q;
        ltype_d      = ltype_q;
        ll_d         = ll_q;
        oldrt_d      = oldrt_q;
        write_data_d = write_data_q;
        reg_write_d  = 1'b0;
        llbit_set_d  = 1'b0;
        addr_err_d   = 1'b0;
        bus_err_d    = 1'b0;
        sc_wb_d      = 1'b0;

        case (state_q)
            ST_IDLE, ST_WB: begin
                state_d = ST_IDLE;
                if (accept) begin
                    regwrite_d = InRegWrite;
                    wreg_d     = InWriteReg;
                    alu_d      = InAluResult;
                    ltype_d    = load_type_e'(InLoadType);
                    ll_d       = InIsLL;
                    oldrt_d    = InOldRt;
                    cnt_d      = '0;
                    if (al_misalign) begin
                        state_d    = ST_WB;
                        addr_err_d = 1'b1;
                    end else if (load_type_e'(InLoadType) != LD_NONE) begin
                        state_d = ST_WAIT;
                    end else begin
                        state_d      = ST_WB;
                        reg_write_d  = InRegWrite && (InWriteReg != 5'd0);
                        write_data_d = InAluResult;
                        sc_wb_d      = InIsSC;
                    end
                end
            end
            ST_WAIT: begin
                if (MemAck) begin
                    state_d      = ST_WB;
                    reg_write_d  = regwrite_q && (wreg_q != 5'd0);
                    write_data_d = al_data;
                    llbit_set_d  = ll_q;
                end else if (TIMEOUT_CYCLES != 0) begin
                    if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                        state_d   = ST_IDLE;
                        bus_err_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            regwrite_q   <= 1'b0;
            wreg_q       <= '0;
            alu_q        <= '0;
            ltype_q      <= LD_NONE;
            ll_q         <= 1'b0;
            oldrt_q      <= '0;
            reg_write_q  <= 1'b0;
            write_data_q <= '0;
            llbit_set_q  <= 1'b0;
            addr_err_q   <= 1'b0;
            bus_err_q    <= 1'b0;
            sc_wb_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            regwrite_q   <= regwrite_d;
            wreg_q       <= wreg_d;
            alu_q        <= alu_d;
            ltype_q      <= ltype_d;
            ll_q         <= ll_d;
            oldrt_q      <= oldrt_d;
            reg_write_q  <= reg_write_d;
            write_data_q <= write_data_d;
            llbit_set_q  <= llbit_set_d;
            addr_err_q   <= addr_err_d;
            bus_err_q    <= bus_err_d;
            sc_wb_q      <= sc_wb_d;
        end
    end

    assign InReady  = in_ready;
    assign RegWrite = reg_write_q;
    assign WriteReg = wreg_q;
    // SC reads the link bit during its WB cycle so an LL retiring just ahead is already visible.
    assign WriteData = sc_wb_q ? {31'b0, LLbitout} : write_data_q;
    assign LLbitin  = llbit_set_q;
    assign AddrErr  = addr_err_q;
    assign BusErr   = bus_err_q;

endmodule
